// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the execute-stage HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MADD,
    MD_MADDU,
    MD_MSUB,
    MD_MSUBU,
    MD_MUL
  } funct_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIXUP,
    DONE
  } state_t;

  localparam int CNT_W = 6;

  function automatic logic is_div(input funct_t f);
    return (f == MD_DIV) || (f == MD_DIVU);
  endfunction

  function automatic logic is_signed(input funct_t f);
    return (f == MD_MULT) || (f == MD_DIV) || (f == MD_MADD) ||
           (f == MD_MSUB) || (f == MD_MUL);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [32:0] rem,
  input  logic [31:0] shift,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] shift_next,
  output logic        q_bit
);

  logic [33:0] diff;

  // Partial remainder stays below the divisor, so a negative diff (bit 33) means "restore".
  assign diff       = {rem, shift[31]} - {2'b00, divisor};
  assign q_bit      = ~diff[33];
  assign rem_next   = q_bit ? diff[32:0] : {rem[31:0], shift[31]};
  assign shift_next = {shift[30:0], 1'b0};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO sequencer: fixed-latency multiply/accumulate and a radix-2 restoring divider.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_ITER    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        hold_result,
  input  funct_t      muldiv_funct,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        wait_result,
  output logic        busy
);

  state_t             state;
  funct_t             funct_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        op_a, op_b, acc_hi, acc_lo;
  logic [32:0]        rem_q;
  logic [31:0]        dvd_q, quo_q;

  logic               start, sgn;
  logic [63:0]        ext_a, ext_b, prod, mul_res;
  logic [31:0]        b_mag, quo_fix, rem_fix;
  logic [32:0]        rem_next;
  logic [31:0]        dvd_next;
  logic               q_bit;

  assign start = (muldiv_funct != MD_NONE) && !clear;
  assign sgn   = is_signed(funct_q);

  // Product is formed from latched operands; the multi-cycle window gives it room to settle.
  assign ext_a = sgn ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
  assign ext_b = sgn ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
  assign prod  = ext_a * ext_b;

  always_comb begin
    mul_res = prod;
    case (funct_q)
      MD_MADD, MD_MADDU: mul_res = {acc_hi, acc_lo} + prod;
      MD_MSUB, MD_MSUBU: mul_res = {acc_hi, acc_lo} - prod;
      default:           mul_res = prod;
    endcase
  end

  assign b_mag   = (sgn && op_b[31]) ? (32'd0 - op_b) : op_b;
  assign quo_fix = (sgn && (op_a[31] ^ op_b[31])) ? (32'd0 - quo_q) : quo_q;
  assign rem_fix = (sgn && op_a[31]) ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  div_step u_div_step (
    .rem        (rem_q),
    .shift      (dvd_q),
    .divisor    (b_mag),
    .rem_next   (rem_next),
    .shift_next (dvd_next),
    .q_bit      (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      funct_q <= MD_NONE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          funct_q <= muldiv_funct;
          op_a    <= rs;
          op_b    <= rt;
          acc_hi  <= hi_in;
          acc_lo  <= lo_in;
          if (is_div(muldiv_funct)) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= (is_signed(muldiv_funct) && rs[31]) ? (32'd0 - rs) : rs;
            cnt   <= CNT_W'(DIV_ITER - 1);
            state <= (rt == 32'd0) ? FIXUP : DIV;
          end else begin
            cnt   <= CNT_W'(MUL_LATENCY - 1);
            state <= MUL;
          end
        end
        MUL: if (cnt == '0) begin
          lo_out <= mul_res[31:0];
          if (funct_q != MD_MUL) hi_out <= mul_res[63:32];
          state <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          rem_q <= rem_next;
          dvd_q <= dvd_next;
          quo_q <= {quo_q[30:0], q_bit};
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - 1'b1;
        end
        FIXUP: begin
          if (op_b == 32'd0) begin
            lo_out <= 32'hFFFF_FFFF;
            hi_out <= op_a;
          end else begin
            lo_out <= quo_fix;
            hi_out <= rem_fix;
          end
          state <= DONE;
        end
        DONE:    if (!hold_result) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wait_result = !reset && ((state == IDLE && start) || state == MUL ||
                                  state == DIV || state == FIXUP);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, arithmetic corners, clear, hold and async reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, hold_result;
  funct_t      muldiv_funct;
  logic [31:0] rs, rt, hi_in, lo_in, hi_out, lo_out;
  logic        wait_result, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .hold_result  (hold_result),
    .muldiv_funct (muldiv_funct),
    .rs           (rs),
    .rt           (rt),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .wait_result  (wait_result),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns the number of cycles wait_result stayed high.
  task automatic run_op(input funct_t f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, output int cycles);
    muldiv_funct = f;
    rs = a; rt = b; hi_in = h; lo_in = l;
    #1;
    cycles = 0;
    while (wait_result === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk); #1;
    end
  endtask

  task automatic leave(input string tag);
    muldiv_funct = MD_NONE;
    @(negedge clk); #1;
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; hold_result = 1'b0;
    muldiv_funct = MD_MULT; rs = 32'd5; rt = 32'd6; hi_in = '0; lo_in = '0;
    @(negedge clk); #1;
    check("rst_hi",   hi_out, 64'd0);
    check("rst_lo",   lo_out, 64'd0);
    check("rst_wait", {63'd0, wait_result}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    muldiv_funct = MD_NONE;
    reset = 1'b0;
    @(negedge clk); #1;
    check("idle_wait", {63'd0, wait_result}, 64'd0);

    run_op(MD_MULT, 32'hFFFF_FFFB, 32'd7, '0, '0, cyc);
    check("mult_cyc",  64'(cyc), 64'd4);
    check("mult_hi",   hi_out, 64'hFFFF_FFFF);
    check("mult_lo",   lo_out, 64'hFFFF_FFDD);
    check("mult_wait", {63'd0, wait_result}, 64'd0);
    leave("mult_idle");

    run_op(MD_DIVU, 32'd100, 32'd7, '0, '0, cyc);
    check("divu_cyc", 64'(cyc), 64'd34);
    check("divu_lo",  lo_out, 64'd14);
    check("divu_hi",  hi_out, 64'd2);
    leave("divu_idle");

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, cyc);
    check("div_cyc", 64'(cyc), 64'd34);
    check("div_lo",  lo_out, 64'hFFFF_FFFD);
    check("div_hi",  hi_out, 64'hFFFF_FFFF);
    leave("div_idle");

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, cyc);
    check("ovf_lo", lo_out, 64'h8000_0000);
    check("ovf_hi", hi_out, 64'd0);
    leave("ovf_idle");

    run_op(MD_DIVU, 32'h1234, 32'd0, '0, '0, cyc);
    check("dz_cyc", 64'(cyc), 64'd2);
    check("dz_lo",  lo_out, 64'hFFFF_FFFF);
    check("dz_hi",  hi_out, 64'h1234);
    leave("dz_idle");

    run_op(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, cyc);
    check("maddu_cyc", 64'(cyc), 64'd4);
    check("maddu_hi",  hi_out, 64'd1);
    check("maddu_lo",  lo_out, 64'd0);
    leave("maddu_idle");

    run_op(MD_MUL, 32'd6, 32'hFFFF_FFFE, '0, '0, cyc);
    check("mul_lo", lo_out, 64'hFFFF_FFF4);
    check("mul_hi_kept", hi_out, 64'd1);
    leave("mul_idle");

    run_op(MD_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, cyc);
    check("msub_hi", hi_out, 64'hFFFF_FFFF);
    check("msub_lo", lo_out, 64'hFFFF_FFFF);
    leave("msub_idle");

    // clear in IDLE suppresses start
    muldiv_funct = MD_MULT; clear = 1'b1; #1;
    check("clr_idle_wait", {63'd0, wait_result}, 64'd0);
    @(negedge clk); #1;
    check("clr_idle_busy", {63'd0, busy}, 64'd0);
    clear = 1'b0; muldiv_funct = MD_NONE;
    @(negedge clk); #1;

    // clear mid divide
    muldiv_funct = MD_DIVU; rs = 32'd1000; rt = 32'd3; #1;
    repeat (10) @(negedge clk);
    #1;
    check("clr_div_busy", {63'd0, busy}, 64'd1);
    clear = 1'b1; muldiv_funct = MD_NONE;
    @(negedge clk); #1;
    clear = 1'b0;
    check("clr_div_wait", {63'd0, wait_result}, 64'd0);
    check("clr_div_idle", {63'd0, busy}, 64'd0);
    check("clr_div_hi",   hi_out, 64'hFFFF_FFFF);
    check("clr_div_lo",   lo_out, 64'hFFFF_FFFF);

    run_op(MD_MULTU, 32'd3, 32'd4, '0, '0, cyc);
    check("multu_cyc", 64'(cyc), 64'd4);
    check("multu_lo",  lo_out, 64'd12);
    check("multu_hi",  hi_out, 64'd0);
    leave("multu_idle");

    // hold in DONE with the instruction still present
    run_op(MD_MULT, 32'd2, 32'd3, '0, '0, cyc);
    hold_result = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold_busy", {63'd0, busy}, 64'd1);
      check("hold_wait", {63'd0, wait_result}, 64'd0);
      check("hold_lo",   lo_out, 64'd6);
      check("hold_hi",   hi_out, 64'd0);
    end
    hold_result = 1'b0;
    leave("hold_idle");

    // asynchronous reset mid divide, sampled before the next rising edge
    muldiv_funct = MD_DIV; rs = 32'd50; rt = 32'd5; #1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_hi",   hi_out, 64'd0);
    check("arst_lo",   lo_out, 64'd0);
    check("arst_wait", {63'd0, wait_result}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    muldiv_funct = MD_NONE;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("arst_after", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
